pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit for the in-order integer core. It produces the hold (stall) and flush (kill) controls for the fetch/decode, decode/execute and execute/memory latches. It resolves load-use hazards, multi-cycle multiply occupancy, data-cache miss waits, taken branches and exceptions. It sits beside the datapath and is the sole driver of every latch `stall_core_i`/`kill_i` input.

## Interface
- `MUL_LAT`, default 4: total cycles a multiply occupies execute (≥2).
- `CNT_W`, default 3: width of the multiply countdown; must hold `MUL_LAT-1`.
- `clk_i  in  1`: single core clock; everything samples on its rising edge.
- `rst_i  in  1`: reset, synchronous and active-high.
- `dec_rs1_addr_i  in  5`, `dec_rs1_used_i  in  1`: decode-stage source 1 and its valid.
- `dec_rs2_addr_i  in  5`, `dec_rs2_used_i  in  1`: decode-stage source 2 and its valid.
- `dec_is_mul_i  in  1`: the instruction in decode is a multi-cycle multiply.
- `exe_write_addr_i  in  5`, `exe_int_write_enable_i  in  1`, `exe_is_load_i  in  1`: execute-stage destination info.
- `exe_branch_taken_i  in  1`: execute resolved a taken branch or jump this cycle.
- `mem_miss_i  in  1`: data-cache miss raised in memory this cycle.
- `mem_ready_i  in  1`: miss fill complete.
- `exc_i  in  1`: exception committed at writeback.
- `stall_fetch_o  out  1`: hold the PC and the fetch/decode latch.
- `stall_core_o  out  1`: hold the decode/execute latch.
- `stall_exe_o  out  1`: hold the execute/memory latch.
- `kill_fd_o  out  1`: flush the fetch/decode latch.
- `kill_de_o  out  1`: flush the decode/execute latch (bubble into execute).
- `kill_em_o  out  1`: flush the execute/memory latch (bubble into memory).
- `stall_cycles_o  out  32`: saturating count of cycles with `stall_core_o` high.

## Operation
- States: RUN, MUL, MEM. Registers: `state`, `mul_cnt[CNT_W]`, `resume_mul` (1 bit), `stall_cycles`.
- Outputs are combinational from the registered state and the current inputs. They take effect at the same edge the latches sample.
- Priority, highest first: `rst_i`, then `exc_i`, then `mem_miss_i`/MEM, then MUL, then branch, then load-use.
- `exc_i` (any state): assert `kill_fd_o`, `kill_de_o` and `kill_em_o`; all stall outputs low. Next state RUN; clear `mul_cnt` and `resume_mul`.
- RUN, `mem_miss_i`: all three stalls high, no kills. Next state MEM.
- RUN, `exe_branch_taken_i`: `kill_fd_o` and `kill_de_o` high, no stall.
- RUN, load-use: the condition is `exe_is_load_i && exe_int_write_enable_i && exe_write_addr_i!=0`, plus a match on a used source (`rs1` or `rs2`).
  - Response: `stall_fetch_o` and `stall_core_o` high, `kill_em_o` high.
  - The load proceeds to memory while a bubble follows it.
  - Lasts exactly one cycle, because the load then leaves execute.
- RUN, `dec_is_mul_i` with no stall and no kill that cycle: the multiply enters execute. Next state MUL, `mul_cnt <= MUL_LAT-2`.
- A branch and a load-use hazard in the same cycle: the branch wins and no stall is raised.
- MUL:
  - `stall_fetch_o`, `stall_core_o` and `kill_em_o` high; `stall_exe_o` low. The multiplier holds its own operands.
  - `mul_cnt` decrements each cycle; at 0, next state RUN.
  - Branch and load-use are ignored while in MUL.
- MUL with `mem_miss_i`: all stalls high, `kill_em_o` low. Next state MEM, `resume_mul <= 1`, `mul_cnt` frozen.
- MEM: all three stalls high, no kills.
  - On `mem_ready_i`: next state MUL if `resume_mul`, else RUN; clear `resume_mul`.
  - The ready cycle is still a stall cycle.
- `stall_cycles` increments when `stall_core_o` is high and saturates at `32'hFFFF_FFFF`.

## Timing
- Reset: on a `rst_i` edge, state RUN, `mul_cnt`=0, `resume_mul`=0, `stall_cycles_o`=0.
- While `rst_i` is high, all stall outputs are 0 and all kill outputs are 1, so the latches clear with the core.
- A reset mid-MUL or mid-MEM abandons the operation.
- Load-use: penalty of 1 cycle.
- Taken branch: penalty of 2 cycles; the kills are asserted in the resolve cycle.
- Multiply occupies execute for exactly `MUL_LAT` cycles: 1 RUN issue-exit cycle plus `MUL_LAT-1` MUL cycles.
- MEM: minimum 1 cycle; exit on the edge after `mem_ready_i` is sampled high.
- `mem_ready_i` outside MEM is ignored. `mem_miss_i` inside MEM is ignored.

## Structure
- Shared core package holds:
  - the state enum (RUN=2'd0, MUL=2'd1, MEM=2'd2);
  - `REG_ADDR_W`=5;
  - `MUL_LAT` default.
- Optional sub-module `hazard_cmp`: combinational load-use compare of two sources against the execute destination.

## Test plan
- Load to x5 in execute; decode uses rs1=x5 -> one cycle with `stall_fetch_o=1`, `stall_core_o=1`, `kill_em_o=1`; then RUN with no stall; `stall_cycles_o`=1.
- Load to x0, decode uses x0 -> no stall.
- Multiply issued, `MUL_LAT`=4 -> MUL for 3 cycles with `stall_core_o=1`, then RUN; `stall_cycles_o`=3.
- `mem_miss_i` on the 2nd MUL cycle, `mem_ready_i` 5 cycles later -> MEM with all stalls high for 6 cycles; then MUL resumes with its remaining count (2 cycles) and returns to RUN.
- `exe_branch_taken_i` and load-use hazard in the same RUN cycle -> `kill_fd_o=1`, `kill_de_o=1`, no stall.
- `exc_i` during MEM -> all three kills high, no stalls; next cycle RUN; a later `mem_ready_i` is ignored.
- `rst_i` pulse mid-MUL -> next cycle RUN, `stall_cycles_o`=0, kills high while reset is held.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register address width and the default multiply latency.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MUL_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    StRun = 2'd0,
    StMul = 2'd1,
    StMem = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use detector: flags a decode source that reads the
// destination of a load currently in execute.
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic                  rs1_used_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  rs2_used_i,
  input  logic [REG_ADDR_W-1:0] exe_write_addr_i,
  input  logic                  exe_int_write_enable_i,
  input  logic                  exe_is_load_i,
  output logic                  hazard_o
);

  logic load_dst_valid;
  logic rs1_match;
  logic rs2_match;

  always_comb begin
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    load_dst_valid = exe_is_load_i && exe_int_write_enable_i &&
                     (exe_write_addr_i != '0);
    rs1_match      = rs1_used_i && (rs1_addr_i == exe_write_addr_i);
    rs2_match      = rs2_used_i && (rs2_addr_i == exe_write_addr_i);
    hazard_o       = load_dst_valid && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: resolves load-use, multi-cycle multiply,
// data-cache miss, taken-branch and exception hazards for the three latches.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
  input  logic                  dec_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
  input  logic                  dec_rs2_used_i,
  input  logic                  dec_is_mul_i,
  input  logic [REG_ADDR_W-1:0] exe_write_addr_i,
  input  logic                  exe_int_write_enable_i,
  input  logic                  exe_is_load_i,
  input  logic                  exe_branch_taken_i,
  input  logic                  mem_miss_i,
  input  logic                  mem_ready_i,
  input  logic                  exc_i,
  output logic                  stall_fetch_o,
  output logic                  stall_core_o,
  output logic                  stall_exe_o,
  output logic                  kill_fd_o,
  output logic                  kill_de_o,
  output logic                  kill_em_o,
  output logic [31:0]           stall_cycles_o
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             resume_mul_q, resume_mul_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic             load_use;

  pipe_hazard_ctrl_hazard_cmp u_hazard_cmp (
    .rs1_addr_i             (dec_rs1_addr_i),
    .rs1_used_i             (dec_rs1_used_i),
    .rs2_addr_i             (dec_rs2_addr_i),
    .rs2_used_i             (dec_rs2_used_i),
    .exe_write_addr_i       (exe_write_addr_i),
    .exe_int_write_enable_i (exe_int_write_enable_i),
    .exe_is_load_i          (exe_is_load_i),
    .hazard_o               (load_use)
  );

  always_comb begin
    state_d       = state_q;
    mul_cnt_d     = mul_cnt_q;
    resume_mul_d  = resume_mul_q;
    stall_fetch_o = 1'b0;
    stall_core_o  = 1'b0;
    stall_exe_o   = 1'b0;
    kill_fd_o     = 1'b0;
    kill_de_o     = 1'b0;
    kill_em_o     = 1'b0;

    if (rst_i) begin
      // Latches clear together with the controller
      kill_fd_o    = 1'b1;
      kill_de_o    = 1'b1;
      kill_em_o    = 1'b1;
      state_d      = StRun;
      mul_cnt_d    = '0;
      resume_mul_d = 1'b0;
    end else if (exc_i) begin
      kill_fd_o    = 1'b1;
      kill_de_o    = 1'b1;
      kill_em_o    = 1'b1;
      state_d      = StRun;
      mul_cnt_d    = '0;
      resume_mul_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_miss_i) begin
            stall_fetch_o = 1'b1;
            stall_core_o  = 1'b1;
            stall_exe_o   = 1'b1;
            state_d       = StMem;
          end else if (exe_branch_taken_i) begin
            kill_fd_o = 1'b1;
            kill_de_o = 1'b1;
          end else if (load_use) begin
            // Load moves on to memory; a bubble follows it
            stall_fetch_o = 1'b1;
            stall_core_o  = 1'b1;
            kill_em_o     = 1'b1;
          end else if (dec_is_mul_i) begin
            state_d   = StMul;
            mul_cnt_d = CNT_W'(MUL_LAT - 2);
          end
        end
        StMul: begin
          if (mem_miss_i) begin
            stall_fetch_o = 1'b1;
            stall_core_o  = 1'b1;
            stall_exe_o   = 1'b1;
            state_d       = StMem;
            resume_mul_d  = 1'b1;
          end else begin
            // Multiplier holds its own operands, so only bubbles leave execute
            stall_fetch_o = 1'b1;
            stall_core_o  = 1'b1;
            kill_em_o     = 1'b1;
            if (mul_cnt_q == '0) begin
              state_d = StRun;
            end else begin
              mul_cnt_d = mul_cnt_q - CNT_W'(1);
            end
          end
        end
        StMem: begin
          stall_fetch_o = 1'b1;
          stall_core_o  = 1'b1;
          stall_exe_o   = 1'b1;
          if (mem_ready_i) begin
            state_d      = resume_mul_q ? StMul : StRun;
            resume_mul_d = 1'b0;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_core_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StRun;
      mul_cnt_q      <= '0;
      resume_mul_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mul_cnt_q      <= mul_cnt_d;
      resume_mul_q   <= resume_mul_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
